// File: rtl/rv32_mod_load_store_unit.sv
// RV32 load/store unit: one aligned single-beat data bus access per request,
// with load extension and misaligned/bus-error/timeout reporting.
module rv32_mod_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_ram_req,
  input  logic        lsu_ram_wr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  width_q, width_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        is_b, is_h, is_w;
  logic        fault, timeout;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic [15:0] lane;
  logic [31:0] ext;
  logic        unused;

  assign unused = lsu_ram_req[3];

  always_comb begin
    is_b   = lsu_ram_req[1:0] == 2'b00;
    is_h   = lsu_ram_req[1:0] == 2'b01;
    is_w   = lsu_ram_req[1:0] == 2'b10;
    fault  = (is_h && lsu_addr[0])
           | (is_w && (|lsu_addr[1:0]))
           | (lsu_ram_req[1:0] == 2'b11)
           | (lsu_ram_wr && lsu_ram_req[2]);
    be_new = 4'b1111;
    wd_new = lsu_wdata;
    unique case (1'b1)
      is_b: begin
        be_new = 4'b0001 << lsu_addr[1:0];
        wd_new = {4{lsu_wdata[7:0]}};
      end
      is_h: begin
        be_new = 4'b0011 << lsu_addr[1:0];
        wd_new = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = 16'(bus_rdata >> {off_q, 3'b000});
    ext  = bus_rdata;
    unique case (width_q)
      2'b00:   ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   ext = {{16{~uns_q & lane[15]}}, lane};
      default: ;
    endcase
    timeout = cnt_q == CntLast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (lsu_valid) state_d = fault ? DONE : WAIT;
      WAIT:    if (bus_err || bus_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_ready = state_q == IDLE;
    lsu_done  = state_q == DONE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    off_d   = off_q;
    width_d = width_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: if (lsu_valid) begin
        off_d   = lsu_addr[1:0];
        width_d = lsu_ram_req[1:0];
        uns_d   = lsu_ram_req[2];
        rdata_d = '0;
        err_d   = fault;
        cause_d = fault ? 2'd1 : 2'd0;
        cnt_d   = '0;
        if (!fault) begin
          cyc_d   = 1'b1;
          we_d    = lsu_ram_wr;
          addr_d  = {lsu_addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = lsu_ram_wr ? wd_new : '0;
        end
      end
      WAIT: begin
        if (bus_err || bus_ack || timeout) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
        end
        // Error outranks ack; ack outranks the final timeout cycle.
        if (bus_err) begin
          err_d   = 1'b1;
          cause_d = 2'd2;
        end else if (bus_ack) begin
          rdata_d = we_q ? '0 : ext;
          err_d   = 1'b0;
          cause_d = 2'd0;
        end else if (timeout) begin
          err_d   = 1'b1;
          cause_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        cause_d = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      off_q   <= '0;
      width_q <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign lsu_rdata     = rdata_q;
  assign lsu_err       = err_q;
  assign lsu_err_cause = cause_q;
  assign bus_cyc       = cyc_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_be        = be_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Bench for rv32_mod_load_store_unit: directed plan cases plus random
// requests checked against an arithmetic reference model.
module tb_rv32_mod_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [3:0]  lsu_ram_req;
  logic        lsu_ram_wr;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [1:0]  lsu_err_cause;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;
  int          last_cycles;

  rv32_mod_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_ram_req(lsu_ram_req), .lsu_ram_wr(lsu_ram_wr),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 ack, 1 err, 2 ack+err; delay >= TO means no response.
  task automatic model(input logic [3:0] req, input bit wr,
                       input logic [31:0] addr, wd, rd,
                       input int delay, input int kind,
                       output bit fault, output logic [3:0] be,
                       output logic [31:0] bwd, output logic [31:0] res,
                       output logic [1:0] cause, output int cycles);
    int n, off;
    longint v, mask;
    off = int'(addr % 4);
    case (req[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 0;
    endcase
    fault = (n == 0) || wr && req[2];
    if (n != 0 && (addr % n) != 0) fault = 1;
    be  = 4'(((1 << n) - 1) << off);
    if (n == 1)      bwd = (wd & 32'hFF) * 32'h0101_0101;
    else if (n == 2) bwd = (wd & 32'hFFFF) * 32'h0001_0001;
    else             bwd = wd;
    mask = (64'd1 << (8 * n)) - 1;
    v = (longint'(rd) >> (8 * off)) & mask;
    if (!req[2] && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    res = 32'(v);
    res = 32'(v);
    if (fault) begin
      cause = 1; cycles = 0; res = 0;
    end else if (delay < TO) begin
      cause = (kind == 0) ? 2'd0 : 2'd2;
      cycles = delay + 1;
      if (cause != 0 || wr) res = 0;
    end else begin
      cause = 3; cycles = TO; res = 0;
    end
  endtask

  task automatic xact(input logic [3:0] req, input bit wr,
                      input logic [31:0] addr, wd, rd,
                      input int delay, input int kind);
    bit fault;
    logic [3:0] ebe;
    logic [31:0] ebwd, eres;
    logic [1:0] ecause;
    int ecyc, cyc;
    model(req, wr, addr, wd, rd, delay, kind,
          fault, ebe, ebwd, eres, ecause, ecyc);
    chk("ready_idle", 32'(lsu_ready), 1);
    lsu_valid = 1; lsu_ram_req = req; lsu_ram_wr = wr;
    lsu_addr = addr; lsu_wdata = wd; bus_rdata = rd;
    @(posedge clk); #1;
    lsu_valid = 0;
    lsu_wdata = $urandom;
    cyc = 0;
    if (!fault) begin
      chk("cyc_start", 32'(bus_cyc), 1);
      chk("bus_addr", bus_addr, addr & ~32'd3);
      chk("bus_be", 32'(bus_be), 32'(ebe));
      chk("bus_we", 32'(bus_we), 32'(wr));
      if (wr) chk("bus_wdata", bus_wdata, ebwd);
      last_addr = bus_addr; last_be = bus_be;
      last_we = bus_we; last_wdata = bus_wdata;
      while (bus_cyc === 1'b1 && cyc < 40) begin
        if (cyc == delay) begin
          bus_ack = (kind != 1);
          bus_err = (kind != 0);
        end
        @(posedge clk); #1;
        bus_ack = 0; bus_err = 0;
        cyc++;
        if (bus_cyc === 1'b1) chk("be_stable", 32'(bus_be), 32'(ebe));
      end
    end
    last_cycles = cyc;
    chk("wait_cycles", cyc, ecyc);
    chk("done", 32'(lsu_done), 1);
    chk("bus_cyc_off", 32'(bus_cyc), 0);
    chk("err", 32'(lsu_err), 32'(ecause != 0));
    chk("cause", 32'(lsu_err_cause), 32'(ecause));
    chk("rdata", lsu_rdata, eres);
    last_rdata = lsu_rdata;
    @(posedge clk); #1;
    chk("done_clr", 32'(lsu_done), 0);
    chk("rdata_clr", lsu_rdata, 0);
    chk("ready_back", 32'(lsu_ready), 1);
    if (fault) chk("no_cyc_fault", 32'(bus_cyc), 0);
  endtask

  initial begin
    rst_n = 0; lsu_valid = 0; lsu_ram_req = 0; lsu_ram_wr = 0;
    lsu_addr = 0; lsu_wdata = 0; bus_ack = 0; bus_err = 0;
    bus_rdata = 0;
    #12;
    chk("rst_ready", 32'(lsu_ready), 1);
    chk("rst_done", 32'(lsu_done), 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_err", {29'd0, lsu_err, lsu_err_cause}, 0);
    chk("rst_bus", {bus_cyc, bus_we, bus_be, 26'd0}, 0);
    chk("rst_baddr", bus_addr, 0);
    chk("rst_bwd", bus_wdata, 0);
    rst_n = 1;
    @(posedge clk); #1;

    xact(4'b0000, 0, 32'h1003, 0, 32'h80FF_1234, 2, 0);
    chk("p1_addr", last_addr, 32'h1000);
    chk("p1_be", 32'(last_be), 32'b1000);
    chk("p1_rdata", last_rdata, 32'hFFFF_FF80);
    chk("p1_cycles", last_cycles, 3);

    xact(4'b0101, 0, 32'h2002, 0, 32'h8001_0000, 0, 0);
    chk("p2_be", 32'(last_be), 32'b1100);
    chk("p2_rdata", last_rdata, 32'h0000_8001);

    xact(4'b0000, 1, 32'h41, 32'hDEAD_BEA5, 32'h1234_5678, 0, 0);
    chk("p3_we", 32'(last_we), 1);
    chk("p3_be", 32'(last_be), 32'b0010);
    chk("p3_wdata", last_wdata, 32'hA5A5_A5A5);
    chk("p3_rdata", last_rdata, 0);

    xact(4'b0010, 0, 32'h6, 0, 0, 0, 0);
    xact(4'b0001, 1, 32'h5, 32'h1111, 0, 0, 0);

    xact(4'b0010, 0, 32'h100, 0, 32'hCAFE_F00D, 9, 0);
    chk("p5_timeout_cycles", last_cycles, 4);
    xact(4'b0010, 0, 32'h104, 0, 32'hCAFE_F00D, 1, 2);

    // Reset while the bus cycle is open
    lsu_valid = 1; lsu_ram_req = 4'b0010; lsu_ram_wr = 0;
    lsu_addr = 32'h200;
    @(posedge clk); #1;
    lsu_valid = 0;
    chk("rw_cyc_up", 32'(bus_cyc), 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rw_cyc_drop", 32'(bus_cyc), 0);
    chk("rw_ready", 32'(lsu_ready), 1);
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rw_no_done", 32'(lsu_done), 0);
    end
    xact(4'b0010, 0, 32'h200, 0, 32'h0BAD_CAFE, 1, 0);
    chk("rw_next", last_rdata, 32'h0BAD_CAFE);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] rq;
      logic [31:0] ad;
      int kd;
      rq = 4'($urandom);
      ad = $urandom;
      if ($urandom_range(1, 0) == 1) ad[1:0] = 2'b00;
      kd = ($urandom_range(9, 0) < 7) ? 0 : int'($urandom_range(2, 1));
      xact(rq, 1'($urandom), ad, $urandom, $urandom,
           int'($urandom_range(5, 0)), kd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_mod_load_store_unit.md
Name: rv32_mod_load_store_unit

Overview:
- Memory-access stage directly downstream of the instruction function decoder.
- Consumes decoded `ram_req`/`ram_wr` together with the ALU-computed effective address and the rs2 store data.
- Runs one aligned single-beat transaction on the data bus and returns sign- or zero-extended load data for the `WB_SOURCE_LSU` writeback path.
- Flags misaligned accesses, illegal widths, bus errors and bus timeouts without issuing or hanging a bus cycle.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles in WAIT before a bus transaction is abandoned. Legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_valid  in  1  request present from execute.
- lsu_ready  out  1  unit can accept a request this cycle.
- lsu_ram_req  in  4  decoder `ram_req`:
  - [1:0] width: 00 byte, 01 half, 10 word, 11 illegal.
  - [2] unsigned (loads only).
  - [3] ignored.
- lsu_ram_wr  in  1  1 = store, 0 = load.
- lsu_addr  in  32  effective byte address.
- lsu_wdata  in  32  store data (rs2).
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  32  extended load data, valid while `lsu_done`; 0 for stores and errors.
- lsu_err  out  1  valid with `lsu_done`; access failed.
- lsu_err_cause  out  2  valid with `lsu_done`: 0 none, 1 misaligned/illegal, 2 bus error, 3 timeout.
- bus_cyc  out  1  bus transaction active.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address: {lsu_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; `bus_rdata` valid.
- bus_err  in  1  transaction failed.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, timeout counter=0.
  - lsu_ready=1 (combinational from IDLE).
  - lsu_done=0, lsu_rdata=0, lsu_err=0, lsu_err_cause=0.
  - bus_cyc=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - Reset mid-transaction drops `bus_cyc` immediately; the request is lost and no `lsu_done` is produced.
- States: IDLE, WAIT, DONE. `lsu_ready` = (state==IDLE).
- IDLE:
  - A request is accepted on clk edge when lsu_valid=1; address, width, sign, direction and data are registered.
  - Alignment check on accept: half with addr[0]=1, word with addr[1:0]!=0, width 11, or store with ram_req[2]=1 → fault.
  - Fault → DONE with err=1, cause=1, and no bus cycle.
  - Otherwise → WAIT with bus_cyc=1 from the next cycle.
- Bus outputs in WAIT are registered and held stable until termination.
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{d[7:0]}}.
  - Half: be = 4'b0011 << addr[1:0]; wdata = {2{d[15:0]}}.
  - Word: be = 4'b1111; wdata = d.
  - Loads drive the same `bus_be`, with bus_we=0.
- WAIT:
  - bus_ack=1 → capture data, → DONE, cause=0.
  - bus_err=1 → DONE, err=1, cause=2. bus_err takes priority if ack and err are both high.
  - Counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES-1 without ack/err → DONE, cause=3.
  - `bus_cyc` deasserts on the same edge that leaves WAIT.
  - The counter clears on entering WAIT.
- Load extraction: lane = bus_rdata >> (8*addr[1:0]).
  - Byte: {24{sign?lane[7]:0}, lane[7:0]}.
  - Half: {16{sign?lane[15]:0}, lane[15:0]}.
  - Word: bus_rdata.
  - sign = !ram_req[2].
- DONE: lsu_done=1 for exactly one cycle with registered lsu_rdata/err/cause, then → IDLE. Those outputs return to 0 outside DONE.
- Latency:
  - Accept at edge N, bus_cyc high in cycle N+1.
  - With ack sampled at edge M, lsu_done is high in cycle M+1 and lsu_ready in cycle M+2.
  - Zero-wait bus: 3 cycles from accept to ready.
  - Fault path: done in cycle N+1.
- lsu_valid while not ready is ignored; the upstream stage holds the request.
- No outstanding transactions beyond one; no write buffering.

Test Plan:
- Signed byte load, addr=0x1003, bus_rdata=0x80FF_1234, ack after 2 wait cycles → bus_addr=0x1000, be=1000, lsu_rdata=0xFFFF_FF80, err=0.
- Unsigned half load (ram_req=4'b0101), addr=0x2002, rdata=0x8001_0000 → be=1100, lsu_rdata=0x0000_8001.
- Byte store, addr=0x41, wdata=0xDEAD_BEA5, immediate ack → bus_we=1, be=0010, bus_wdata=0xA5A5_A5A5, done with rdata=0.
- Word load at addr=0x6, then half store at 0x5 → each gives done in the cycle after accept with err=1, cause=1, and bus_cyc never asserted.
- Timeout and bus error:
  - TIMEOUT_CYCLES=4, no ack → bus_cyc high exactly 4 cycles, then done with cause=3.
  - Separate run, ack and err both high together → cause=2.
- rst_n pulsed low while in WAIT → bus_cyc=0 asynchronously, no done, lsu_ready=1 after release; the next request completes normally.
